mem_access_master: RTL and testbench
====================================

// Module: mem_access_master
// PURPOSE
//   Initiator side of the 8-bit data-memory port: takes load/store requests from the MEM
//   pipeline stage and sequences them onto data_memory (byte or little-endian halfword).
//   Memory side: combinational read; write commits at posedge clk.
//   Sits between the EX/MEM pipeline register and data_memory; req_ready backpressures
//   the pipeline (stall) while an access is in flight.
// PARAMETERS
//   ADDR_W  8  memory address width; addresses wrap modulo 2**ADDR_W
//   BYTE_W  8  memory data width; halfword = 2*BYTE_W
// PORTS
//   clk             in   1         clock, all state updates on posedge
//   rst             in   1         synchronous, active-high reset
//   req_valid       in   1         pipeline presents a request
//   req_ready       out  1         master can accept a request this cycle
//   req_write       in   1         1 = store, 0 = load
//   req_size        in   1         0 = byte, 1 = halfword
//   req_addr        in   ADDR_W    byte address of the (low) byte
//   req_wdata       in   2*BYTE_W  store data; byte store uses [BYTE_W-1:0]
//   resp_valid      out  1         one-cycle completion pulse
//   resp_rdata      out  2*BYTE_W  load result, zero-extended for byte; 0 for stores
//   mem_address     out  ADDR_W    to data_memory address
//   mem_write_data  out  BYTE_W    to data_memory write_data
//   mem_write       out  1         to data_memory mem_write
//   mem_read        out  1         to data_memory mem_read
//   mem_read_data   in   BYTE_W    from data_memory read_data (same-cycle)
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; mem_write=0, mem_read=0,
//     mem_address=0, mem_write_data=0. Reset mid-access abandons it: no resp, no further writes.
//   - FSM: IDLE -> ACC0 -> (ACC1 if halfword) -> RESP -> IDLE.
//   - IDLE: req_ready=1. On req_valid: latch write, size, addr, wdata; go ACC0. No memory strobe.
//   - ACC0: mem_address=addr; store: mem_write=1, mem_write_data=wdata[7:0];
//     load: mem_read=1, capture mem_read_data into rdata[7:0] at clock edge. Then ACC1 or RESP.
//   - ACC1: mem_address=addr+1 (mod 2**ADDR_W, 0xFF wraps to 0x00); store drives wdata[15:8];
//     load captures into rdata[15:8].
//   - RESP: resp_valid=1 for exactly one cycle; resp_rdata valid this cycle, held until next RESP.
//     req_ready=0 in RESP. Next cycle IDLE.
//   - req_ready=0 in ACC0/ACC1/RESP. Request inputs ignored outside IDLE.
//   - Latency, accept edge to resp_valid: byte 2 cycles, halfword 3 cycles.
//   - Throughput: one request per 3 (byte) or 4 (halfword) cycles.
//   - mem_read and mem_write never both 1. Both 0 in IDLE and RESP.
//   - mem_address/mem_write_data are 0 whenever no strobe is active.
//   - Byte load: resp_rdata[15:8]=0. Store: resp_rdata=0 and resp_valid still pulses (ack).
// STRUCTURE
//   - Shared package mem_pkg: state encoding (IDLE/ACC0/ACC1/RESP), size codes SZ_BYTE=0 /
//     SZ_HALF=1, ADDR_W/BYTE_W defaults.
//     data_memory and the pipeline both use these.
//   - Single flat module; no natural sub-module (address incrementer is one adder).
// TESTING (bench instantiates mem_access_master + data_memory)
//   - Reset: hold rst 2 cycles -> all outputs at reset values; rst low -> req_ready=1
//     next cycle.
//   - Byte store 0xA5 @0x10, then byte load @0x10 -> resp_rdata=0x00A5, resp_valid 2 cycles
//     after accept, single pulse.
//   - Halfword store 0xBEEF @0x20 -> mem[0x20]=0xEF, mem[0x21]=0xBE;
//     halfword load @0x20 -> 0xBEEF at 3 cycles.
//   - Wrap: halfword store 0x1234 @0xFF -> mem[0xFF]=0x34, mem[0x00]=0x12;
//     load @0xFF -> 0x1234.
//   - Backpressure: req_valid held high continuously -> req_ready low in ACC0/ACC1/RESP,
//     exactly one accept per FSM pass; no double write.
//   - Reset mid-halfword-store (rst in ACC0) -> mem[addr+1] unchanged, no resp_valid,
//     IDLE after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: FSM state encoding, access size codes
// and default widths used by mem_access_master, data_memory and the pipeline.
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_HALF = 1'b1;

endpackage

// File: rtl/mem_access_master.sv
// Initiator for the byte-wide data memory: sequences byte or little-endian halfword
// loads/stores from the MEM stage, stalling the pipeline while an access is in flight.
module mem_access_master
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int BYTE_W = MEM_BYTE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*BYTE_W-1:0] req_wdata,
    output logic                resp_valid,
    output logic [2*BYTE_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [BYTE_W-1:0]   mem_write_data,
    output logic                mem_write,
    output logic                mem_read,
    input  logic [BYTE_W-1:0]   mem_read_data
);

    logic [1:0]          state;
    logic                q_write;
    logic                q_size;
    logic [ADDR_W-1:0]   q_addr;
    logic [2*BYTE_W-1:0] q_wdata;
    logic [BYTE_W-1:0]   lo_byte;
    logic [2*BYTE_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            q_write <= 1'b0;
            q_size  <= SZ_BYTE;
            q_addr  <= '0;
            q_wdata <= '0;
            lo_byte <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        q_write <= req_write;
                        q_size  <= req_size;
                        q_addr  <= req_addr;
                        q_wdata <= req_wdata;
                        state   <= ST_ACC0;
                    end
                end
                ST_ACC0: begin
                    lo_byte <= mem_read_data;
                    if (q_size == SZ_HALF) begin
                        state <= ST_ACC1;
                    end else begin
                        state <= ST_RESP;
                        rdata <= q_write ? '0 : {{BYTE_W{1'b0}}, mem_read_data};
                    end
                end
                ST_ACC1: begin
                    state <= ST_RESP;
                    rdata <= q_write ? '0 : {mem_read_data, lo_byte};
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result register only changes on entry to RESP, so it holds between responses.
    assign resp_rdata = rdata;

    always_comb begin
        req_ready      = (state == ST_IDLE);
        resp_valid     = (state == ST_RESP);
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (state == ST_ACC0 || state == ST_ACC1) begin
            mem_write = q_write;
            mem_read  = !q_write;
            // Upper byte address wraps naturally at the address width.
            mem_address = (state == ST_ACC1) ? q_addr + ADDR_W'(1) : q_addr;
            if (q_write) begin
                mem_write_data = (state == ST_ACC1) ? q_wdata[2*BYTE_W-1:BYTE_W]
                                                    : q_wdata[BYTE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master against a behavioural byte-wide memory.
module tb_mem_access_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_size;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [7:0]  mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [7:0]  mem_read_data;

    mem_access_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural data memory, preloaded with mem[i] = i.
    logic [7:0] mem [256];
    logic       mem_init;
    int         wr_count = 0;
    assign mem_read_data = mem_read ? mem[mem_address] : 8'h00;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (mem_write) begin
            mem[mem_address] <= mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] rdata;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus invariants every cycle, scoreboard pop on each response pulse.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("rw_exclusive", 32'(mem_read & mem_write), 0);
            if (!mem_read && !mem_write)
                chk("idle_bus_zero", {16'h0, mem_address, mem_write_data}, 0);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_rdata", 32'(resp_rdata), 32'(mon_e.rdata));
                    chk("resp_latency", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(req_ready), 1);
    endtask

    task automatic issue(input logic w, input logic s, input logic [7:0] a,
                         input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t e;
        wait_ready();
        req_valid = 1'b1;
        req_write = w;
        req_size  = s;
        req_addr  = a;
        req_wdata = wd;
        e.rdata = exp_rd;
        e.due   = cyc + (s ? 3 : 2);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   w0;
        int   c0;
        exp_t e;
        rst = 1'b1;
        mem_init = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 1'b0;
        req_addr = 8'h00;
        req_wdata = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_rdata", 32'(resp_rdata), 0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 0);
        chk("rst_bus", {16'h0, mem_address, mem_write_data}, 0);
        mem_init = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 1);

        // Byte store / load round trip
        issue(1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000);
        issue(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5);
        drain();

        // Halfword little-endian layout
        issue(1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000);
        drain();
        chk("mem_20", 32'(mem[8'h20]), 32'h00EF);
        chk("mem_21", 32'(mem[8'h21]), 32'h00BE);
        issue(1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF);
        issue(1'b0, 1'b0, 8'h21, 16'h0000, 16'h00BE);
        drain();

        // Address wrap at 0xFF
        issue(1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000);
        drain();
        chk("mem_ff", 32'(mem[8'hFF]), 32'h0034);
        chk("mem_00", 32'(mem[8'h00]), 32'h0012);
        issue(1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234);
        drain();

        // Byte store writes only the low data byte
        issue(1'b1, 1'b0, 8'h50, 16'hFF77, 16'h0000);
        issue(1'b0, 1'b1, 8'h50, 16'h0000, 16'h5177);
        drain();

        // Backpressure: request held high for 9 cycles gives 3 byte stores
        wait_ready();
        w0 = wr_count;
        c0 = cyc;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 1'b0;
        req_addr  = 8'h30;
        req_wdata = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            e.rdata = 16'h0000;
            e.due   = c0 + 3 * i + 2;
            sb.push_back(e);
        end
        for (int i = 0; i < 9; i++) begin
            chk("bp_ready", 32'(req_ready), ((i % 3) == 0) ? 1 : 0);
            if (i == 8) req_valid = 1'b0;
            @(negedge clk);
        end
        drain();
        chk("bp_write_count", wr_count - w0, 3);
        chk("mem_30", 32'(mem[8'h30]), 32'h0077);

        // Reset during ACC0 of a halfword store abandons the upper byte
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 1'b1;
        req_addr  = 8'h40;
        req_wdata = 16'h5566;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 1);
        chk("midrst_strobes", {30'h0, mem_read, mem_write}, 0);
        repeat (5) @(negedge clk);
        chk("midrst_mem_41", 32'(mem[8'h41]), 32'h0041);

        issue(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
